// File: rtl/axi_4_mst.sv
// AXI4-Lite master: turns single-beat local commands into AXI4-Lite write/read transactions.
// Latency: command accepted at edge T0, rsp_valid high in the third cycle after it (zero-wait slave).
// Backpressure: cmd_ready low from acceptance until the response cycle; AXI VALIDs held until READY.
//
// Ports: M_AXI_ACLK / M_AXI_ARESET (synchronous, active-high); cmd_* command side with
// valid/ready; rsp_* one-cycle response pulse with held data/resp; err_timeout sticky flag;
// M_AXI_* standard AXI4-Lite master channels (AW, W, B, AR, R).
// Optional feature macro: AXI_MST_TIMEOUT_EN enables the B/R response-wait timeout and HALT.

`ifndef C_REGISTERS_NUMBER
`define C_REGISTERS_NUMBER 16
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif

module axi_4_mst #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned ADDR_W         = $clog2(`C_REGISTERS_NUMBER),
  parameter int unsigned DATA_W         = `C_AXI_DATA_WIDTH
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESET,
  // command / response side
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                err_timeout,
  // write address
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  // write data
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  // write response
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  input  logic [1:0]          M_AXI_BRESP,
  // read address
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  // read data
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, HALT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
  } cmd_t;

  state_t state;
  cmd_t   cmd_q;
  logic   aw_done;
  logic   w_done;

  logic aw_hs;
  logic w_hs;
  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;

  // Address/data buses come straight from the registered command, so they cannot
  // move while the matching VALID is up.
  assign M_AXI_AWADDR = cmd_q.addr;
  assign M_AXI_WDATA  = cmd_q.wdata;
  assign M_AXI_WSTRB  = cmd_q.wstrb;
  assign M_AXI_ARADDR = cmd_q.addr;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

`ifdef AXI_MST_TIMEOUT_EN
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state         <= IDLE;
      cmd_q         <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
`ifdef AXI_MST_TIMEOUT_EN
      tmo_cnt       <= '0;
      err_timeout   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          // cmd_ready is registered: it is still low the first cycle out of reset,
          // and a command seen then is ignored.
          if (cmd_valid && cmd_ready) begin
            cmd_q.addr  <= cmd_addr;
            cmd_q.wdata <= cmd_wdata;
            cmd_q.wstrb <= cmd_wstrb;
            cmd_ready   <= 1'b0;
            if (cmd_wr) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WR_REQ;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_REQ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        WR_REQ: begin
          // AW and W retire independently; the done flags remember the earlier one.
          if (aw_hs) M_AXI_AWVALID <= 1'b0;
          if (w_hs)  M_AXI_WVALID  <= 1'b0;
          aw_done <= aw_done || aw_hs;
          w_done  <= w_done  || w_hs;
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
`ifdef AXI_MST_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
          end
        end

        WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= M_AXI_BRESP;
            cmd_ready    <= 1'b1;
            state        <= IDLE;
          end
`ifdef AXI_MST_TIMEOUT_EN
          // Last allowed empty cycle: the count would reach TIMEOUT_CYCLES here.
          else if (tmo_cnt == TMO_LAST) begin
            M_AXI_BREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= 2'b11;
            err_timeout  <= 1'b1;
            state        <= HALT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        RD_REQ: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_RESP;
`ifdef AXI_MST_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end

        RD_RESP: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            cmd_ready    <= 1'b1;
            state        <= IDLE;
          end
`ifdef AXI_MST_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            M_AXI_RREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= 2'b11;
            err_timeout  <= 1'b1;
            state        <= HALT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        // Only a reset leaves HALT; cmd_ready stays low.
        HALT: cmd_ready <= 1'b0;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_4_mst.sv
// Testbench for axi_4_mst: behavioural AXI4-Lite slave plus a response/latency reference model.
// Latency expectations derive from slave wait-state settings (AW/W/B/AR/R delays).
// Slave delays, response codes and command mix are randomized with $urandom.

module tb_axi_4_mst;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int TMO    = 8;
  localparam int TRL    = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              M_AXI_ARESET;
  logic              cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              err_timeout;
  logic              M_AXI_AWVALID, M_AXI_AWREADY;
  logic [ADDR_W-1:0] M_AXI_AWADDR;
  logic [2:0]        M_AXI_AWPROT;
  logic              M_AXI_WVALID, M_AXI_WREADY;
  logic [DATA_W-1:0] M_AXI_WDATA;
  logic [STRB_W-1:0] M_AXI_WSTRB;
  logic              M_AXI_BVALID, M_AXI_BREADY;
  logic [1:0]        M_AXI_BRESP;
  logic              M_AXI_ARVALID, M_AXI_ARREADY;
  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic [2:0]        M_AXI_ARPROT;
  logic              M_AXI_RVALID, M_AXI_RREADY;
  logic [DATA_W-1:0] M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;

  axi_4_mst #(.TIMEOUT_CYCLES(TMO), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(M_AXI_ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_timeout(err_timeout),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWADDR(M_AXI_AWADDR),
    .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- slave configuration and state ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit b_en = 1'b1, r_en = 1'b1;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  logic [DATA_W-1:0] slv_mem [16];
  bit aw_got, w_got, ar_got, b_hs, r_hs;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [ADDR_W-1:0] s_awa, s_ara;
  logic [DATA_W-1:0] s_wd;
  logic [STRB_W-1:0] s_ws;

  // Slave drives on the falling edge; a VALID/READY pair seen high here
  // completes at the next rising edge.
  initial begin
    for (int i = 0; i < 16; i++) slv_mem[i] = '0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    s_awa = '0; s_ara = '0; s_wd = '0; s_ws = '0;
    forever begin
      @(negedge clk);
      if (M_AXI_ARESET) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (b_hs) begin
          for (int b = 0; b < STRB_W; b++)
            if (s_ws[b]) slv_mem[s_awa][b*8 +: 8] = s_wd[b*8 +: 8];
          M_AXI_BVALID = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else if (aw_got && w_got && !M_AXI_BVALID && b_en) begin
          if (b_cnt >= b_dly) begin M_AXI_BVALID = 1; M_AXI_BRESP = bresp_cfg; end
          else b_cnt++;
        end
        if (M_AXI_AWVALID && !aw_got) begin
          if (aw_cnt >= aw_dly) begin M_AXI_AWREADY = 1; aw_got = 1; s_awa = M_AXI_AWADDR; end
          else begin M_AXI_AWREADY = 0; aw_cnt++; end
        end else M_AXI_AWREADY = 0;
        if (M_AXI_WVALID && !w_got) begin
          if (w_cnt >= w_dly) begin M_AXI_WREADY = 1; w_got = 1; s_wd = M_AXI_WDATA; s_ws = M_AXI_WSTRB; end
          else begin M_AXI_WREADY = 0; w_cnt++; end
        end else M_AXI_WREADY = 0;
        if (r_hs) begin
          M_AXI_RVALID = 0; M_AXI_RDATA = $urandom; ar_got = 0; ar_cnt = 0; r_cnt = 0;
        end else if (ar_got && !M_AXI_RVALID && r_en) begin
          if (r_cnt >= r_dly) begin
            M_AXI_RVALID = 1; M_AXI_RDATA = slv_mem[s_ara]; M_AXI_RRESP = rresp_cfg;
          end else r_cnt++;
        end
        if (M_AXI_ARVALID && !ar_got) begin
          if (ar_cnt >= ar_dly) begin M_AXI_ARREADY = 1; ar_got = 1; s_ara = M_AXI_ARADDR; end
          else begin M_AXI_ARREADY = 0; ar_cnt++; end
        end else M_AXI_ARREADY = 0;
        b_hs = M_AXI_BVALID && M_AXI_BREADY;
        r_hs = M_AXI_RVALID && M_AXI_RREADY;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] model_mem [16];

  function automatic logic [DATA_W-1:0] merge_model(input logic [DATA_W-1:0] old,
                                                     input logic [DATA_W-1:0] wd,
                                                     input logic [STRB_W-1:0] ws);
    logic [DATA_W-1:0] mask = '0;
    for (int b = 0; b < STRB_W; b++) mask[b*8 +: 8] = {8{ws[b]}};
    return (old & ~mask) | (wd & mask);
  endfunction

  // ---------------- per-transaction trace ----------------
  logic              tr_awv [TRL], tr_wv [TRL], tr_bry [TRL], tr_arv [TRL], tr_rry [TRL], tr_crdy [TRL];
  logic [ADDR_W-1:0] tr_awaddr [TRL];

  // Issues one command at the current falling edge and follows it to rsp_valid.
  // lat counts falling edges after the accepting rising edge (cycle 1 = first after T0).
  task automatic do_cmd(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                        input logic [STRB_W-1:0] ws, input bit noise, input int budget,
                        output logic [DATA_W-1:0] rd, output logic [1:0] rs,
                        output int lat, output int acc_wait, output bit tmo);
    tmo = 0; lat = 0; acc_wait = 0; rd = '0; rs = '0;
    cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    while (cmd_ready !== 1'b1 && acc_wait < budget) begin @(negedge clk); acc_wait++; end
    if (cmd_ready !== 1'b1) begin tmo = 1; cmd_valid = 0; return; end
    @(negedge clk); lat = 1;
    if (noise) begin cmd_wr = ~wr; cmd_addr = ADDR_W'($urandom); end
    else cmd_valid = 0;
    while (lat <= budget) begin
      if (lat < TRL) begin
        tr_awv[lat] = M_AXI_AWVALID; tr_wv[lat] = M_AXI_WVALID; tr_bry[lat] = M_AXI_BREADY;
        tr_arv[lat] = M_AXI_ARVALID; tr_rry[lat] = M_AXI_RREADY; tr_crdy[lat] = cmd_ready;
        tr_awaddr[lat] = M_AXI_AWADDR;
      end
      if (rsp_valid === 1'b1) begin cmd_valid = 0; rd = rsp_rdata; rs = rsp_resp; break; end
      @(negedge clk); lat++;
    end
    if (lat > budget) begin tmo = 1; cmd_valid = 0; end
  endtask

  task automatic apply_reset(input int cycles);
    M_AXI_ARESET = 1;
    repeat (cycles) @(negedge clk);
    M_AXI_ARESET = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    M_AXI_ARESET = 1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
         cmd_ready, rsp_valid, err_timeout} !== 8'h00) begin
      n_err++; $display("FAIL reset_ctrl: got %b required 00000000",
        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, cmd_ready, rsp_valid, err_timeout});
    end
    n_cmp++;
    if ({rsp_rdata, rsp_resp, M_AXI_AWPROT, M_AXI_ARPROT} !== '0) begin
      n_err++; $display("FAIL reset_data: rdata %h resp %b awprot %b arprot %b required all 0",
        rsp_rdata, rsp_resp, M_AXI_AWPROT, M_AXI_ARPROT);
    end
    M_AXI_ARESET = 0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_write_basic();
    logic [DATA_W-1:0] rd; logic [1:0] rs; int lat, aw8; bit tmo; int bad;
    aw_dly = 0; w_dly = 0; b_dly = 0; bresp_cfg = 2'b00;
    do_cmd(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 40, rd, rs, lat, aw8, tmo);
    if (!tmo) model_mem[3] = merge_model(model_mem[3], 32'hDEADBEEF, 4'hF);
    n_cmp++;
    if (tmo || lat != 3) begin n_err++; $display("FAIL wr_basic_latency: got %0d (timeout %0d) required 3", lat, tmo); end
    n_cmp++;
    if ({rs, rd} !== {2'b00, 32'h0}) begin n_err++; $display("FAIL wr_basic_rsp: resp %b rdata %h required 00 / 0", rs, rd); end
    bad = 0;
    for (int k = 1; k <= lat && k < TRL; k++) begin
      if (tr_awv[k] !== (k == 1)) bad++;
      if (tr_wv[k]  !== (k == 1)) bad++;
      if (tr_bry[k] !== (k == 2)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL wr_basic_chan_timing: %0d wrong cycles required 0", bad); end
  endtask

  task automatic test_handshake_order();
    int aw_tab [3] = '{4, 0, 2};
    int w_tab  [3] = '{0, 3, 2};
    for (int c = 0; c < 3; c++) begin
      logic [DATA_W-1:0] rd, wd; logic [1:0] rs; logic [ADDR_W-1:0] a; int lat, acc, m, bad; bit tmo;
      aw_dly = aw_tab[c]; w_dly = w_tab[c]; b_dly = 0; bresp_cfg = 2'b00;
      m = (aw_dly > w_dly) ? aw_dly : w_dly;
      a = ADDR_W'($urandom_range(4, 15)); wd = $urandom;
      do_cmd(1'b1, a, wd, 4'hF, 1'b0, 40, rd, rs, lat, acc, tmo);
      if (!tmo) model_mem[a] = merge_model(model_mem[a], wd, 4'hF);
      n_cmp++;
      if (tmo || lat != m + 3) begin n_err++; $display("FAIL hs_order%0d_latency: got %0d required %0d", c, lat, m + 3); end
      bad = 0;
      for (int k = 1; k <= lat && k < TRL; k++) begin
        if (tr_awv[k] !== (k <= aw_dly + 1)) bad++;
        if (tr_wv[k]  !== (k <= w_dly + 1)) bad++;
        if (tr_bry[k] !== (k >= m + 2 && k < lat)) bad++;
        if (k <= aw_dly + 1 && tr_awaddr[k] !== a) bad++;
      end
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL hs_order%0d_chan_timing: %0d wrong cycles required 0", c, bad); end
    end
  endtask

  task automatic test_read_after_write();
    logic [DATA_W-1:0] rd; logic [1:0] rs; int lat, acc; bit tmo;
    ar_dly = 0; r_dly = 2; rresp_cfg = 2'b00;
    do_cmd(1'b0, 4'd3, '0, '0, 1'b0, 40, rd, rs, lat, acc, tmo);
    n_cmp++;
    if (tmo || {rs, rd} !== {2'b00, model_mem[3]}) begin
      n_err++; $display("FAIL rd_after_wr_rsp: resp %b rdata %h required 00 / %h", rs, rd, model_mem[3]);
    end
    n_cmp++;
    if (lat != 5) begin n_err++; $display("FAIL rd_after_wr_latency: got %0d required 5", lat); end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_rsp_pulse_width: rsp_valid %b required 0", rsp_valid); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rsp_rdata !== model_mem[3]) begin n_err++; $display("FAIL rd_rdata_hold: got %h required %h", rsp_rdata, model_mem[3]); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] rd, wd; logic [1:0] rs; int lat, acc; bit tmo;
    ar_dly = 1; r_dly = 0; rresp_cfg = 2'b10;
    aw_dly = 0; w_dly = 0; b_dly = 0; bresp_cfg = 2'b00;
    do_cmd(1'b0, 4'd7, '0, '0, 1'b0, 40, rd, rs, lat, acc, tmo);
    n_cmp++;
    if (tmo || rs !== 2'b10 || rd !== model_mem[7]) begin
      n_err++; $display("FAIL rresp_slverr: resp %b rdata %h required 10 / %h", rs, rd, model_mem[7]);
    end
    wd = $urandom;
    do_cmd(1'b1, 4'd9, wd, 4'b0101, 1'b0, 40, rd, rs, lat, acc, tmo);
    if (!tmo) model_mem[9] = merge_model(model_mem[9], wd, 4'b0101);
    n_cmp++;
    if (acc != 0) begin n_err++; $display("FAIL b2b_accept_wait: got %0d cycles required 0", acc); end
    n_cmp++;
    if (tmo || {rs, rd} !== {2'b00, 32'h0} || lat != 3) begin
      n_err++; $display("FAIL b2b_write_rsp: resp %b rdata %h lat %0d required 00 / 0 / 3", rs, rd, lat);
    end
  endtask

  task automatic test_random();
    int bad_rsp = 0, bad_lat = 0, bad_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      logic [DATA_W-1:0] rd, wd, exp_rd; logic [1:0] rs, exp_rs; logic [ADDR_W-1:0] a;
      logic [STRB_W-1:0] ws; int lat, acc, exp_lat; bit tmo, wr, noise;
      wr = 1'($urandom_range(0, 1)); a = ADDR_W'($urandom_range(0, 15));
      wd = $urandom; ws = STRB_W'($urandom_range(0, 15)); noise = 1'($urandom_range(0, 1));
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      if (wr) begin
        exp_rd = '0; exp_rs = bresp_cfg;
        exp_lat = ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 3;
      end else begin
        exp_rd = model_mem[a]; exp_rs = rresp_cfg; exp_lat = ar_dly + r_dly + 3;
      end
      do_cmd(wr, a, wd, ws, noise, 60, rd, rs, lat, acc, tmo);
      if (wr && !tmo) model_mem[a] = merge_model(model_mem[a], wd, ws);
      if (tmo || acc != 0 || {rs, rd} !== {exp_rs, exp_rd}) begin
        bad_rsp++; $display("FAIL rand%0d_rsp: resp %b rdata %h required %b / %h", i, rs, rd, exp_rs, exp_rd);
      end
      if (lat != exp_lat) begin bad_lat++; $display("FAIL rand%0d_latency: got %0d required %0d", i, lat, exp_lat); end
      for (int k = 1; k <= lat && k < TRL; k++)
        if (tr_crdy[k] !== (k == lat)) bad_rdy++;
    end
    n_cmp++; if (bad_rsp != 0) n_err++;
    n_cmp++; if (bad_lat != 0) n_err++;
    n_cmp++;
    if (bad_rdy != 0) begin n_err++; $display("FAIL rand_cmd_ready_busy: %0d wrong cycles required 0", bad_rdy); end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] rd; logic [1:0] rs; int lat, acc, budget; bit tmo;
    aw_dly = 0; w_dly = 0; b_en = 0;
`ifdef AXI_MST_TIMEOUT_EN
    budget = 6;
`else
    budget = 300;
`endif
    do_cmd(1'b1, 4'd3, 32'h12345678, 4'hF, 1'b0, budget, rd, rs, lat, acc, tmo);
    n_cmp++;
    if (tmo !== 1'b1 || M_AXI_BREADY !== 1'b1 || err_timeout !== 1'b0) begin
      n_err++; $display("FAIL wait_in_wr_resp: timeout %b bready %b err %b required 1 1 0", tmo, M_AXI_BREADY, err_timeout);
    end
    M_AXI_ARESET = 1;
    @(negedge clk);
    n_cmp++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, cmd_ready} !== 7'b0) begin
      n_err++; $display("FAIL mid_reset_outputs: got %b required 0000000",
        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, cmd_ready});
    end
    @(negedge clk);
    M_AXI_ARESET = 0; b_en = 1;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_err++; $display("FAIL post_reset_ready: cmd_ready/rsp_valid %b required 10", {cmd_ready, rsp_valid});
    end
    ar_dly = 0; r_dly = 0; rresp_cfg = 2'b00;
    do_cmd(1'b0, 4'd3, '0, '0, 1'b0, 40, rd, rs, lat, acc, tmo);
    n_cmp++;
    if (tmo || {rs, rd} !== {2'b00, model_mem[3]}) begin
      n_err++; $display("FAIL aborted_write_not_committed: rdata %h required %h", rd, model_mem[3]);
    end
  endtask

`ifdef AXI_MST_TIMEOUT_EN
  task automatic test_timeout();
    logic [DATA_W-1:0] rd; logic [1:0] rs; int lat, acc, bad; bit tmo;
    aw_dly = 0; w_dly = 0; b_en = 0;
    do_cmd(1'b1, 4'd5, 32'hA5A5A5A5, 4'hF, 1'b0, 40, rd, rs, lat, acc, tmo);
    n_cmp++;
    if (tmo || {rs, rd} !== {2'b11, 32'h0} || lat != TMO + 2) begin
      n_err++; $display("FAIL timeout_rsp: resp %b rdata %h lat %0d required 11 / 0 / %0d", rs, rd, lat, TMO + 2);
    end
    bad = 0;
    for (int k = 1; k <= lat && k < TRL; k++) if (tr_bry[k] !== (k >= 2 && k <= TMO + 1)) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL timeout_bready_window: %0d wrong cycles required 0", bad); end
    n_cmp++;
    if (err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b required 1", err_timeout); end
    cmd_valid = 1; cmd_wr = 0; bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || M_AXI_ARVALID !== 1'b0 || err_timeout !== 1'b1) bad++;
    end
    cmd_valid = 0;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL halt_holds: %0d wrong cycles required 0", bad); end
    apply_reset(2); b_en = 1;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, err_timeout} !== 2'b10) begin
      n_err++; $display("FAIL halt_exit_by_reset: cmd_ready/err %b required 10", {cmd_ready, err_timeout});
    end
  endtask
`endif

  initial begin
    M_AXI_ARESET = 1; cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    test_reset();
    test_write_basic();
    test_handshake_order();
    test_read_after_write();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef AXI_MST_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
